// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration writer: register map, the
// per-mode PLL settings table and the sequencer state encoding.
package pll_reconfig_pkg;

    localparam int TABLE_SIZE = 8;
    localparam int TABLE_AW   = 3;
    localparam int LAST_STEP  = 5;

    localparam logic [5:0] PLL_REG_MODE  = 6'd0;
    localparam logic [5:0] PLL_REG_START = 6'd2;
    localparam logic [5:0] PLL_REG_N     = 6'd3;
    localparam logic [5:0] PLL_REG_M     = 6'd4;
    localparam logic [5:0] PLL_REG_C     = 6'd5;
    localparam logic [5:0] PLL_REG_K     = 6'd7;

    // C0 bits [22:18] must be written as zero regardless of the table contents
    localparam logic [31:0] C0_RSVD_MASK = 32'h007C_0000;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] m;
        logic [31:0] c0;
        logic [31:0] k;
    } pll_mode_t;

    localparam pll_mode_t PLL_MODE_TABLE [TABLE_SIZE] = '{
        '{32'h0000_0101, 32'h0000_0808, 32'h0000_0404, 32'h0000_0001},
        '{32'h0000_0202, 32'h0000_0a0a, 32'h0002_0303, 32'h0000_0002},
        '{32'h0000_0101, 32'h0000_1010, 32'h0000_0505, 32'h8000_0000},
        '{32'h0000_0303, 32'h0000_1212, 32'h0000_0606, 32'h0000_0003},
        '{32'h0000_0101, 32'h0000_0c0c, 32'h0000_0202, 32'h0000_0004},
        '{32'h0000_0202, 32'h0000_1414, 32'h0044_0404, 32'h0000_0005},
        '{32'h0000_0505, 32'h0000_1e1e, 32'h0000_0707, 32'h0000_0006},
        '{32'h0000_0101, 32'h0000_0606, 32'h0000_0303, 32'h0000_0007}
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_SETTLE,
        ST_FINISH
    } state_t;

    function automatic logic [5:0] step_addr(input logic [2:0] step);
        case (step)
            3'd0:    step_addr = PLL_REG_MODE;
            3'd1:    step_addr = PLL_REG_N;
            3'd2:    step_addr = PLL_REG_M;
            3'd3:    step_addr = PLL_REG_C;
            3'd4:    step_addr = PLL_REG_K;
            default: step_addr = PLL_REG_START;
        endcase
    endfunction

endpackage

// File: rtl/pll_mode_rom.sv
// Combinational lookup of the PLL settings for one video mode; swap the
// table in the package to retarget a different timing set.
module pll_mode_rom
    import pll_reconfig_pkg::*;
#(
    parameter int MODE_W = 3
) (
    input  logic [MODE_W-1:0] mode_idx,
    output pll_mode_t         row
);

    always_comb begin
        row = '0;
        if (int'(mode_idx) < TABLE_SIZE)
            row = PLL_MODE_TABLE[mode_idx[TABLE_AW-1:0]];
    end

endmodule

// File: rtl/pll_reconfig_writer.sv
// Emits the six-word PLL reconfiguration write sequence for a requested video
// mode into the reconfig FIFO, then waits a settle interval and pulses done.
//
// state     | meaning
// ST_IDLE   | waiting for a mode request
// ST_LOAD   | table row fetched, first word staged
// ST_WRITE  | handing words to the FIFO, one per non-full cycle
// ST_SETTLE | counting the settle interval after the start write
// ST_FINISH | done pulse; chain into the pending request if any
module pll_reconfig_writer
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_MODES     = 8,
    parameter int MODE_W        = 3,
    parameter int SETTLE_CYCLES = 65536,
    parameter int SETTLE_W      = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_req,
    input  logic [MODE_W-1:0] mode_sel,
    output logic [5:0]        pll_addr,
    output logic [31:0]       pll_value,
    output logic              pll_write,
    input  logic              pll_busy,
    output logic              busy,
    output logic              done,
    output logic [MODE_W-1:0] cur_mode,
    output logic              req_err
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state;
    logic [MODE_W-1:0]   mode_q;
    logic [MODE_W-1:0]   pend_mode;
    logic                pend_valid;
    logic [2:0]          step;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                wr_valid;
    logic                mode_ok;
    pll_mode_t           row;

    pll_mode_rom #(.MODE_W(MODE_W)) u_rom (
        .mode_idx (mode_q),
        .row      (row)
    );

    function automatic logic [31:0] step_value(input logic [2:0] s, input pll_mode_t r);
        case (s)
            3'd0:    step_value = 32'd0;
            3'd1:    step_value = r.n;
            3'd2:    step_value = r.m;
            3'd3:    step_value = r.c0 & ~C0_RSVD_MASK;
            3'd4:    step_value = r.k;
            default: step_value = 32'd1;
        endcase
    endfunction

    assign mode_ok   = int'(mode_sel) < NUM_MODES;
    assign pll_write = wr_valid & ~pll_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            mode_q     <= '0;
            pend_mode  <= '0;
            pend_valid <= 1'b0;
            step       <= '0;
            settle_cnt <= '0;
            wr_valid   <= 1'b0;
            pll_addr   <= '0;
            pll_value  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_mode   <= '0;
            req_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            req_err <= mode_req & ~mode_ok;

            // Requests during a sequence never abort it; the latest valid one waits here
            if (mode_req && mode_ok && state != ST_IDLE && state != ST_FINISH) begin
                pend_valid <= 1'b1;
                pend_mode  <= mode_sel;
            end

            case (state)
                ST_IDLE: begin
                    if (mode_req && mode_ok) begin
                        mode_q <= mode_sel;
                        busy   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    step      <= 3'd0;
                    pll_addr  <= step_addr(3'd0);
                    pll_value <= step_value(3'd0, row);
                    wr_valid  <= 1'b1;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!pll_busy) begin
                        if (step == 3'(LAST_STEP)) begin
                            wr_valid   <= 1'b0;
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end else begin
                            step      <= step + 3'd1;
                            pll_addr  <= step_addr(step + 3'd1);
                            pll_value <= step_value(step + 3'd1, row);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        done     <= 1'b1;
                        cur_mode <= mode_q;
                        state    <= ST_FINISH;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    pend_valid <= 1'b0;
                    if (mode_req && mode_ok) begin
                        mode_q <= mode_sel;
                        state  <= ST_LOAD;
                    end else if (pend_valid) begin
                        mode_q <= pend_mode;
                        state  <= ST_LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_writer.sv
// Directed bench for pll_reconfig_writer: table-driven single-mode sequences
// plus hand-written pending, error, reset and back-to-back cases.
module tb_pll_reconfig_writer;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_req;
    logic [3:0]  mode_sel;
    logic [5:0]  pll_addr;
    logic [31:0] pll_value;
    logic        pll_write;
    logic        pll_busy;
    logic        busy;
    logic        done;
    logic [3:0]  cur_mode;
    logic        req_err;

    always #5 clk = ~clk;

    pll_reconfig_writer #(
        .NUM_MODES     (8),
        .MODE_W        (4),
        .SETTLE_CYCLES (SC),
        .SETTLE_W      (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_req  (mode_req),
        .mode_sel  (mode_sel),
        .pll_addr  (pll_addr),
        .pll_value (pll_value),
        .pll_write (pll_write),
        .pll_busy  (pll_busy),
        .busy      (busy),
        .done      (done),
        .cur_mode  (cur_mode),
        .req_err   (req_err)
    );

    typedef struct {
        logic [31:0] n;
        logic [31:0] m;
        logic [31:0] c0;
        logic [31:0] k;
    } row_t;

    typedef struct {
        int mode;
        int stall_len;
        int exp_last;
        int exp_done;
    } vec_t;

    row_t exp_tab [8];
    vec_t vecs [5];
    int   exp_addr [6];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int req_cyc;

    logic [5:0]  wq_addr [$];
    logic [31:0] wq_val  [$];
    int          wq_cyc  [$];
    int          done_q  [$];
    int          err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pll_write === 1'b1) begin
            wq_addr.push_back(pll_addr);
            wq_val.push_back(pll_value);
            wq_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (req_err === 1'b1) err_cnt = err_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_val(input int mode, input int s);
        case (s)
            0:       return 32'd0;
            1:       return exp_tab[mode].n;
            2:       return exp_tab[mode].m;
            3:       return exp_tab[mode].c0;
            4:       return exp_tab[mode].k;
            default: return 32'd1;
        endcase
    endfunction

    task automatic clear_logs();
        wq_addr.delete();
        wq_val.delete();
        wq_cyc.delete();
        done_q.delete();
    endtask

    task automatic pulse_req(input int mode);
        @(posedge clk); #1;
        mode_req = 1'b1;
        mode_sel = 4'(mode);
        req_cyc  = cyc;
        @(posedge clk); #1;
        mode_req = 1'b0;
    endtask

    task automatic check_words(input int base, input int mode);
        for (int s = 0; s < 6; s++) begin
            if (base + s < wq_addr.size()) begin
                check($sformatf("addr m%0d s%0d", mode, s), 32'(wq_addr[base+s]), 32'(exp_addr[s]));
                check($sformatf("value m%0d s%0d", mode, s), wq_val[base+s], exp_val(mode, s));
            end
        end
    endtask

    task automatic wait_dones(input int n, input int budget);
        int t = 0;
        while (done_q.size() < n && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        check("done_count", 32'(done_q.size()), 32'(n));
    endtask

    task automatic run_vec(input vec_t v);
        int r;
        clear_logs();
        pulse_req(v.mode);
        r = req_cyc;
        if (v.stall_len > 0) begin
            repeat (3) @(posedge clk);
            #1;
            pll_busy = 1'b1;
            for (int i = 0; i < v.stall_len; i++) begin
                @(negedge clk);
                check("stall_write", 32'(pll_write), 32'd0);
                check("stall_addr", 32'(pll_addr), 32'd4);
                check("stall_value", pll_value, exp_tab[v.mode].m);
                @(posedge clk); #1;
            end
            pll_busy = 1'b0;
        end
        wait_dones(1, 200);
        check("write_count", 32'(wq_addr.size()), 32'd6);
        check_words(0, v.mode);
        if (wq_cyc.size() == 6) begin
            check("first_write_lat", 32'(wq_cyc[0] - r), 32'd2);
            check("last_write_lat", 32'(wq_cyc[5] - r), 32'(v.exp_last));
        end
        if (done_q.size() > 0) check("done_lat", 32'(done_q[0] - r), 32'(v.exp_done));
        check("cur_mode", 32'(cur_mode), 32'(v.mode));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int r;
        int drops;
        int t;

        exp_tab[0] = '{32'h0000_0101, 32'h0000_0808, 32'h0000_0404, 32'h0000_0001};
        exp_tab[1] = '{32'h0000_0202, 32'h0000_0a0a, 32'h0002_0303, 32'h0000_0002};
        exp_tab[2] = '{32'h0000_0101, 32'h0000_1010, 32'h0000_0505, 32'h8000_0000};
        exp_tab[3] = '{32'h0000_0303, 32'h0000_1212, 32'h0000_0606, 32'h0000_0003};
        exp_tab[4] = '{32'h0000_0101, 32'h0000_0c0c, 32'h0000_0202, 32'h0000_0004};
        exp_tab[5] = '{32'h0000_0202, 32'h0000_1414, 32'h0000_0404, 32'h0000_0005};
        exp_tab[6] = '{32'h0000_0505, 32'h0000_1e1e, 32'h0000_0707, 32'h0000_0006};
        exp_tab[7] = '{32'h0000_0101, 32'h0000_0606, 32'h0000_0303, 32'h0000_0007};
        exp_addr = '{0, 3, 4, 5, 7, 2};
        // mode, stall cycles at step 2, last-write offset, done offset (from request cycle)
        vecs[0] = '{2, 0, 7, 12};
        vecs[1] = '{2, 5, 12, 17};
        vecs[2] = '{5, 0, 7, 12};
        vecs[3] = '{0, 2, 9, 14};
        vecs[4] = '{7, 1, 8, 13};

        reset    = 1'b1;
        mode_req = 1'b0;
        mode_sel = '0;
        pll_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(pll_addr), 32'd0);
        check("rst_value", pll_value, 32'd0);
        check("rst_write", 32'(pll_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cur_mode", 32'(cur_mode), 32'd0);
        check("rst_req_err", 32'(req_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Out-of-range mode: single error pulse, nothing written
        clear_logs();
        t = err_cnt;
        pulse_req(9);
        @(negedge clk);
        check("err_pulse", 32'(req_err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("err_pulse_end", 32'(req_err), 32'd0);
        repeat (8) @(negedge clk);
        #1;
        check("err_count", 32'(err_cnt - t), 32'd1);
        check("err_no_write", 32'(wq_addr.size()), 32'd0);
        check("err_busy_late", 32'(busy), 32'd0);

        // Pending register: 4 is overwritten by 6, invalid 12 leaves 6 in place
        clear_logs();
        t = err_cnt;
        pulse_req(1);
        r = req_cyc;
        pulse_req(4);
        pulse_req(6);
        pulse_req(12);
        wait_dones(2, 300);
        repeat (20) @(negedge clk);
        #1;
        check("pend_write_count", 32'(wq_addr.size()), 32'd12);
        check_words(0, 1);
        check_words(6, 6);
        if (wq_cyc.size() > 6) check("pend_second_start", 32'(wq_cyc[6] - r), 32'd14);
        check("pend_done_total", 32'(done_q.size()), 32'd2);
        check("pend_err_count", 32'(err_cnt - t), 32'd1);
        check("pend_cur_mode", 32'(cur_mode), 32'd6);
        check("pend_busy_after", 32'(busy), 32'd0);

        // Request coincident with FINISH chains without busy dropping
        clear_logs();
        pulse_req(2);
        r = req_cyc;
        repeat (10) @(posedge clk);
        @(posedge clk); #1;
        check("fin_done_at_req", 32'(done), 32'd1);
        mode_req = 1'b1;
        mode_sel = 4'd7;
        @(posedge clk); #1;
        mode_req = 1'b0;
        drops = 0;
        t = 0;
        while (done_q.size() < 2 && t < 200) begin
            @(negedge clk);
            if (!busy) drops++;
            #1;
            t++;
        end
        check("fin_done_count", 32'(done_q.size()), 32'd2);
        check("fin_busy_drops", 32'(drops), 32'd0);
        check("fin_write_count", 32'(wq_addr.size()), 32'd12);
        check_words(0, 2);
        check_words(6, 7);
        if (wq_cyc.size() == 12) begin
            check("fin_first_done", 32'(done_q[0] - wq_cyc[5]), 32'(SC + 1));
            check("fin_second_start", 32'(wq_cyc[6] - r), 32'd14);
        end
        check("fin_cur_mode", 32'(cur_mode), 32'd7);

        // Asynchronous reset while step 3 (addr 5) is presented
        repeat (3) @(posedge clk);
        pulse_req(3);
        repeat (4) @(posedge clk);
        #3;
        check("mid_addr_pre", 32'(pll_addr), 32'd5);
        reset = 1'b1;
        #1;
        check("mid_rst_addr", 32'(pll_addr), 32'd0);
        check("mid_rst_value", pll_value, 32'd0);
        check("mid_rst_write", 32'(pll_write), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cur_mode", 32'(cur_mode), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_vec('{3, 0, 7, 12});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_writer.md
Name: pll_reconfig_writer

Overview:
Write-side producer for the PLL reconfiguration path. On a video-mode request it reads the mode's PLL settings from a constant table and emits the ordered register-write sequence (mode, N, M, C0, K, start) as {pll_addr, pll_value, pll_write} words into the clk-domain side of pll_fifo, respecting pll_busy (FIFO full). After the writes it waits a settle interval and then reports completion. It sits inside system and drives the system's pll_addr/pll_value/pll_write outputs.

Parameters:
NUM_MODES, 8, number of table entries (video modes)
MODE_W, 3, width of mode_sel (clog2 NUM_MODES)
SETTLE_CYCLES, 65536, clk cycles to wait after the start write before done
SETTLE_W, 17, settle counter width (must hold SETTLE_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mode_req  in  1  one-cycle request strobe
mode_sel  in  MODE_W  requested mode index, sampled with mode_req
pll_addr  out  6  reconfig register address, registered
pll_value  out  32  reconfig register data, registered
pll_write  out  1  write strobe to FIFO; = wr_valid & ~pll_busy (combinational)
pll_busy  in  1  FIFO full; no write accepted while high
busy  out  1  high from request acceptance until done
done  out  1  one-cycle pulse at end of settle
cur_mode  out  MODE_W  last mode fully sequenced
req_err  out  1  one-cycle pulse: mode_sel >= NUM_MODES

Behaviour:
- Reset (async, any state): state=IDLE, wr_valid=0, pll_addr=0, pll_value=0, busy=0, done=0, req_err=0, cur_mode=0, pending cleared, settle count=0. Partial sequences already in the FIFO are not retracted; the next request rewrites the full set.
- States: IDLE, LOAD, WRITE, SETTLE, FINISH.
- IDLE: mode_req with valid mode_sel -> latch mode, busy=1, go LOAD next cycle. Invalid mode_sel -> req_err pulse next cycle, stay IDLE.
- LOAD: step=0; table row fetched; set pll_addr/pll_value for step 0; wr_valid=1; -> WRITE.
- WRITE: word handed over in the cycle where pll_write=1 (wr_valid & ~pll_busy). On handover, step+1 and next addr/value load the following cycle (wr_valid stays 1, so back-to-back writes at 1 word/cycle when not busy). addr/value held stable while pll_busy=1. Step order: 0 addr 0 value 0 (waitrequest mode); 1 addr 3 N; 2 addr 4 M; 3 addr 5 C0 (value[22:18]=0); 4 addr 7 K; 5 addr 2 value 1 (start). After step 5 handover: wr_valid=0, settle count=0, -> SETTLE.
- SETTLE: count up each cycle; at SETTLE_CYCLES-1 -> FINISH.
- FINISH: done=1 for one cycle, cur_mode=latched mode; if pending valid -> LOAD with pending mode (busy stays 1, pending cleared), else busy=0 -> IDLE.
- mode_req while busy (any state but IDLE): valid mode stored in single pending register, last request wins; invalid -> req_err, pending untouched. Requests never abort an in-flight sequence.
- mode_req in the same cycle FINISH clears pending: new request wins (becomes the next sequence).
- Minimum latency, pll_busy=0: request edge -> first pll_write 2 cycles; six writes on consecutive cycles; done SETTLE_CYCLES+1 cycles after last write.

Decomposition:
- Package pll_reconfig_pkg: register address constants (PLL_REG_MODE=0, START=2, N=3, M=4, C=5, K=7), pll_mode_t struct {n, m, c0, k: 32-bit pre-encoded}, constant PLL_MODE_TABLE[NUM_MODES], state enum.
- Single sub-module: pll_mode_rom (combinational/registered lookup of pll_mode_t by index), so the table is swappable per video timing set.

Test Plan:
- Reset, mode_req mode_sel=2, pll_busy=0 -> pll_write on 6 consecutive cycles starting 2 cycles after request; addr sequence 0,3,4,5,7,2; values match table row 2, last value 1; done after SETTLE_CYCLES+1; cur_mode=2.
- Same, pll_busy held 1 for 5 cycles during step 2 -> pll_write=0 those cycles, addr=4/value stable, sequence resumes unchanged, no duplicate or lost word.
- Requests mode 1 then, while busy, mode 4 then mode 6 -> first sequence for 1 completes, one done, then exactly one sequence for 6 (4 dropped); cur_mode ends 6.
- mode_sel=9 with NUM_MODES=8 -> req_err one pulse, no pll_write, busy stays 0.
- Reset asserted mid step 3 -> all outputs 0 immediately (async); next request produces the full 6-word sequence from step 0.
- SETTLE_CYCLES=4 override: done exactly 5 cycles after start write; mode_req coincident with FINISH starts new sequence without busy dropping.
